// File: rtl/cr_clk_lpmd_ctrl.sv
// cr_clk_lpmd_ctrl
// Low-power-mode clock controller for the core clock gate.
//
// When the core requests sleep (WFI), the controller waits for the bus to be
// idle for IDLE_CYC consecutive cycles and then turns the core clock enable
// off. An interrupt or debugger request brings the clock back after WAKE_CYC
// settle cycles, and a one-cycle wake_done pulse marks the re-enable.
//
// Parameters:
//   IDLE_CYC  consecutive bus-idle cycles before clock-off (1..15)
//   WAKE_CYC  settle cycles after wakeup before clock re-enable (1..15)
//
// Ports:
//   forever_cpuclk      free-running core clock (only clock)
//   cpu_rst             asynchronous active-high reset
//   pad_yy_test_mode    scan/test mode, forces the clock enable on
//   cp0_lpmd_sleep_req  level sleep request from the core
//   biu_lpmd_bus_idle   no outstanding bus transaction
//   clic_lpmd_wakeup    level interrupt wakeup request
//   had_lpmd_dbg_req    debugger request (blocks sleep entry, wakes)
//   lpmd_core_clk_en    enable to the core gated-clock cell
//   lpmd_sleep_ack      high while the core clock is off (SLEEP/WAKE)
//   lpmd_wake_done      one-cycle pulse on clock re-enable
//   lpmd_state          current FSM state
module cr_clk_lpmd_ctrl #(
  parameter int IDLE_CYC = 4,
  parameter int WAKE_CYC = 3
) (
  input  logic       forever_cpuclk,
  input  logic       cpu_rst,
  input  logic       pad_yy_test_mode,
  input  logic       cp0_lpmd_sleep_req,
  input  logic       biu_lpmd_bus_idle,
  input  logic       clic_lpmd_wakeup,
  input  logic       had_lpmd_dbg_req,
  output logic       lpmd_core_clk_en,
  output logic       lpmd_sleep_ack,
  output logic       lpmd_wake_done,
  output logic [1:0] lpmd_state
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    SLEEP = 2'b10,
    WAKE  = 2'b11
  } state_e;

  localparam logic [3:0] IDLE_LAST = 4'(IDLE_CYC - 1);
  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic [3:0] wake_cnt_q, wake_cnt_d;
  logic       clk_en_q, clk_en_d;
  logic       ack_q, ack_d;
  logic       wake_done_q, wake_done_d;
  logic       wake;

  assign wake = clic_lpmd_wakeup | had_lpmd_dbg_req;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      RUN: begin
        // Counters are held at zero here so both start clean on entry.
        idle_cnt_d = 4'd0;
        wake_cnt_d = 4'd0;
        if (cp0_lpmd_sleep_req && !wake) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Abort beats the SLEEP transition when both happen together.
        if (wake || !cp0_lpmd_sleep_req) begin
          state_d    = RUN;
          idle_cnt_d = 4'd0;
        end else if (biu_lpmd_bus_idle) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d    = SLEEP;
            idle_cnt_d = 4'd0;
          end else begin
            idle_cnt_d = idle_cnt_q + 4'd1;
          end
        end else begin
          idle_cnt_d = 4'd0;
        end
      end
      SLEEP: begin
        // Only a wake source leaves SLEEP; dropping sleep_req does not.
        if (wake) begin
          state_d    = WAKE;
          wake_cnt_d = 4'd0;
        end
      end
      WAKE: begin
        // Settle runs to completion regardless of the wake level.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = RUN;
          wake_cnt_d = 4'd0;
        end else begin
          wake_cnt_d = wake_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d    = RUN;
        idle_cnt_d = 4'd0;
        wake_cnt_d = 4'd0;
      end
    endcase

    // Outputs are computed from the next state so the flops track the
    // state register cycle for cycle.
    clk_en_d    = (state_d == RUN) || (state_d == DRAIN);
    ack_d       = (state_d == SLEEP) || (state_d == WAKE);
    wake_done_d = (state_q == WAKE) && (state_d == RUN);
  end

  always_ff @(posedge forever_cpuclk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q     <= RUN;
      idle_cnt_q  <= 4'd0;
      wake_cnt_q  <= 4'd0;
      clk_en_q    <= 1'b1;
      ack_q       <= 1'b0;
      wake_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      clk_en_q    <= clk_en_d;
      ack_q       <= ack_d;
      wake_done_q <= wake_done_d;
    end
  end

  // Test mode overrides only the enable; sequencing is untouched.
  assign lpmd_core_clk_en = clk_en_q | pad_yy_test_mode;
  assign lpmd_sleep_ack   = ack_q;
  assign lpmd_wake_done   = wake_done_q;
  assign lpmd_state       = state_q;

endmodule

// File: tb/tb_cr_clk_lpmd_ctrl.sv
// Directed testbench for cr_clk_lpmd_ctrl. Two instances share all inputs:
// dut_a uses the default parameters, dut_b uses IDLE_CYC=1, WAKE_CYC=1.
// Observed tuple per instance: {state[1:0], clk_en, sleep_ack, wake_done}.
module tb_cr_clk_lpmd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tm, sreq, idle, wk, dbg;
  logic       en_a, ack_a, wd_a;
  logic [1:0] st_a;
  logic       en_b, ack_b, wd_b;
  logic [1:0] st_b;

  int checks = 0;
  int errors = 0;

  cr_clk_lpmd_ctrl dut_a (
    .forever_cpuclk     (clk),
    .cpu_rst            (rst),
    .pad_yy_test_mode   (tm),
    .cp0_lpmd_sleep_req (sreq),
    .biu_lpmd_bus_idle  (idle),
    .clic_lpmd_wakeup   (wk),
    .had_lpmd_dbg_req   (dbg),
    .lpmd_core_clk_en   (en_a),
    .lpmd_sleep_ack     (ack_a),
    .lpmd_wake_done     (wd_a),
    .lpmd_state         (st_a)
  );

  cr_clk_lpmd_ctrl #(.IDLE_CYC(1), .WAKE_CYC(1)) dut_b (
    .forever_cpuclk     (clk),
    .cpu_rst            (rst),
    .pad_yy_test_mode   (tm),
    .cp0_lpmd_sleep_req (sreq),
    .biu_lpmd_bus_idle  (idle),
    .clic_lpmd_wakeup   (wk),
    .had_lpmd_dbg_req   (dbg),
    .lpmd_core_clk_en   (en_b),
    .lpmd_sleep_ack     (ack_b),
    .lpmd_wake_done     (wd_b),
    .lpmd_state         (st_b)
  );

  function automatic logic [4:0] obs_a();
    return {st_a, en_a, ack_a, wd_a};
  endfunction

  function automatic logic [4:0] obs_b();
    return {st_b, en_b, ack_b, wd_b};
  endfunction

  // Expected tuples
  localparam logic [4:0] E_RUN    = 5'b00_1_0_0;
  localparam logic [4:0] E_RUN_WD = 5'b00_1_0_1;
  localparam logic [4:0] E_DRAIN  = 5'b01_1_0_0;
  localparam logic [4:0] E_SLEEP  = 5'b10_0_1_0;
  localparam logic [4:0] E_WAKE   = 5'b11_0_1_0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tm = 1'b0; sreq = 1'b0; idle = 1'b1; wk = 1'b0; dbg = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_a() !== E_RUN) begin
      errors++;
      $display("FAIL reset_a: got %b want %b", obs_a(), E_RUN);
    end
    checks++;
    if (obs_b() !== E_RUN) begin
      errors++;
      $display("FAIL reset_b: got %b want %b", obs_b(), E_RUN);
    end
    step();
    checks++;
    if (obs_a() !== E_RUN) begin
      errors++;
      $display("FAIL reset_release_a: got %b want %b", obs_a(), E_RUN);
    end
    $display("test_reset done");
  endtask

  task automatic test_normal();
    do_reset();
    sreq = 1'b1; idle = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (obs_a() !== E_DRAIN) begin
        errors++;
        $display("FAIL normal_drain%0d: got %b want %b", i, obs_a(), E_DRAIN);
      end
    end
    step();
    checks++;
    if (obs_a() !== E_SLEEP) begin
      errors++;
      $display("FAIL normal_sleep: got %b want %b", obs_a(), E_SLEEP);
    end
    // Dropping sleep_req alone must not leave SLEEP
    sreq = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (obs_a() !== E_SLEEP) begin
        errors++;
        $display("FAIL normal_sleep_hold%0d: got %b want %b", i, obs_a(), E_SLEEP);
      end
    end
    wk = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (obs_a() !== E_WAKE) begin
        errors++;
        $display("FAIL normal_wake%0d: got %b want %b", i, obs_a(), E_WAKE);
      end
      wk = 1'b0; // deassert during WAKE: must not abort
    end
    step();
    checks++;
    if (obs_a() !== E_RUN_WD) begin
      errors++;
      $display("FAIL normal_wake_done: got %b want %b", obs_a(), E_RUN_WD);
    end
    step();
    checks++;
    if (obs_a() !== E_RUN) begin
      errors++;
      $display("FAIL normal_wake_done_single: got %b want %b", obs_a(), E_RUN);
    end
    $display("test_normal done");
  endtask

  task automatic test_idle_interrupt();
    logic [7:0] pat;
    pat = 8'b1111_0111; // applied LSB first: 1,1,1,0,1,1,1,1
    do_reset();
    sreq = 1'b1; idle = 1'b1;
    step();
    checks++;
    if (obs_a() !== E_DRAIN) begin
      errors++;
      $display("FAIL idle_enter: got %b want %b", obs_a(), E_DRAIN);
    end
    for (int i = 0; i < 8; i++) begin
      idle = pat[i];
      step();
      checks++;
      if (obs_a() !== ((i == 7) ? E_SLEEP : E_DRAIN)) begin
        errors++;
        $display("FAIL idle_pat%0d: got %b want %b", i, obs_a(),
                 (i == 7) ? E_SLEEP : E_DRAIN);
      end
    end
    $display("test_idle_interrupt done");
  endtask

  task automatic test_priority();
    do_reset();
    sreq = 1'b1; dbg = 1'b1; idle = 1'b1;
    step();
    step();
    checks++;
    if (obs_a() !== E_RUN) begin
      errors++;
      $display("FAIL prio_run_block: got %b want %b", obs_a(), E_RUN);
    end
    dbg = 1'b0;
    step();
    step();
    checks++;
    if (obs_a() !== E_DRAIN) begin
      errors++;
      $display("FAIL prio_drain: got %b want %b", obs_a(), E_DRAIN);
    end
    dbg = 1'b1;
    step();
    checks++;
    if (obs_a() !== E_RUN) begin
      errors++;
      $display("FAIL prio_dbg_abort: got %b want %b", obs_a(), E_RUN);
    end
    step();
    checks++;
    if (obs_a() !== E_RUN) begin
      errors++;
      $display("FAIL prio_no_wake_done: got %b want %b", obs_a(), E_RUN);
    end
    dbg = 1'b0;
    step();
    sreq = 1'b0; // abort by sleep_req deassertion
    step();
    checks++;
    if (obs_a() !== E_RUN) begin
      errors++;
      $display("FAIL prio_sreq_abort: got %b want %b", obs_a(), E_RUN);
    end
    $display("test_priority done");
  endtask

  task automatic test_test_mode();
    do_reset();
    sreq = 1'b1; idle = 1'b1;
    repeat (5) step();
    tm = 1'b1;
    #1;
    checks++;
    if (obs_a() !== 5'b10_1_1_0) begin
      errors++;
      $display("FAIL tmode_override: got %b want %b", obs_a(), 5'b10_1_1_0);
    end
    step();
    checks++;
    if (obs_a() !== 5'b10_1_1_0) begin
      errors++;
      $display("FAIL tmode_hold: got %b want %b", obs_a(), 5'b10_1_1_0);
    end
    tm = 1'b0;
    #1;
    checks++;
    if (obs_a() !== E_SLEEP) begin
      errors++;
      $display("FAIL tmode_release: got %b want %b", obs_a(), E_SLEEP);
    end
    $display("test_test_mode done");
  endtask

  task automatic test_reset_mid_wake();
    do_reset();
    sreq = 1'b1; idle = 1'b1;
    repeat (5) step();
    wk = 1'b1;
    step();
    step();
    checks++;
    if (obs_a() !== E_WAKE) begin
      errors++;
      $display("FAIL rstwake_pre: got %b want %b", obs_a(), E_WAKE);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs_a() !== E_RUN) begin
      errors++;
      $display("FAIL rstwake_async: got %b want %b", obs_a(), E_RUN);
    end
    step();
    rst = 1'b0; wk = 1'b0; sreq = 1'b0;
    step();
    checks++;
    if (obs_a() !== E_RUN) begin
      errors++;
      $display("FAIL rstwake_no_wd: got %b want %b", obs_a(), E_RUN);
    end
    $display("test_reset_mid_wake done");
  endtask

  task automatic test_boundary();
    do_reset();
    sreq = 1'b1; idle = 1'b1;
    step();
    checks++;
    if (obs_b() !== E_DRAIN) begin
      errors++;
      $display("FAIL bound_drain: got %b want %b", obs_b(), E_DRAIN);
    end
    step();
    checks++;
    if (obs_b() !== E_SLEEP) begin
      errors++;
      $display("FAIL bound_sleep: got %b want %b", obs_b(), E_SLEEP);
    end
    sreq = 1'b0; wk = 1'b1;
    step();
    checks++;
    if (obs_b() !== E_WAKE) begin
      errors++;
      $display("FAIL bound_wake: got %b want %b", obs_b(), E_WAKE);
    end
    step();
    checks++;
    if (obs_b() !== E_RUN_WD) begin
      errors++;
      $display("FAIL bound_wake_done: got %b want %b", obs_b(), E_RUN_WD);
    end
    wk = 1'b0;
    step();
    checks++;
    if (obs_b() !== E_RUN) begin
      errors++;
      $display("FAIL bound_run: got %b want %b", obs_b(), E_RUN);
    end
    $display("test_boundary done");
  endtask

  initial begin
    rst = 1'b1; tm = 1'b0; sreq = 1'b0; idle = 1'b1; wk = 1'b0; dbg = 1'b0;
    test_reset();
    test_normal();
    test_idle_interrupt();
    test_priority();
    test_test_mode();
    test_reset_mid_wake();
    test_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
